// File: rtl/beat_clock_pkg.sv
// Shared types and constants for the beat clock and its tempo selector.
package beat_clock_pkg;

    localparam int TEMPO_W = 23;
    localparam int STEPS   = 8;
    localparam int CLK_HZ  = 4_000_000;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Beat period minus one, in clk cycles, for a given BPM.
    function automatic logic [TEMPO_W-1:0] bpm_period(input int bpm);
        return TEMPO_W'((CLK_HZ * 60) / bpm - 1);
    endfunction

    localparam logic [TEMPO_W-1:0] PERIOD_BPM_80  = bpm_period(80);
    localparam logic [TEMPO_W-1:0] PERIOD_BPM_100 = bpm_period(100);
    localparam logic [TEMPO_W-1:0] PERIOD_BPM_120 = bpm_period(120);
    localparam logic [TEMPO_W-1:0] PERIOD_BPM_140 = bpm_period(140);

endpackage

// File: rtl/beat_clock_period_counter.sv
// Beat period counter: counts up to a latched tempo and flags the terminal cycle.
module period_counter #(
    parameter int TEMPO_W = beat_clock_pkg::TEMPO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               zero,
    input  logic               advance,
    input  logic [TEMPO_W-1:0] tempo,
    output logic               terminal
);
    import beat_clock_pkg::*;

    logic [TEMPO_W-1:0] count_q, count_d;
    logic [TEMPO_W-1:0] active_tempo_q, active_tempo_d;

    assign terminal = (count_q == active_tempo_q);

    // tempo is only latched when a new beat begins, so mid-beat changes wait
    always_comb begin
        count_d        = count_q;
        active_tempo_d = active_tempo_q;
        if (restart) begin
            count_d        = '0;
            active_tempo_d = tempo;
        end else if (zero) begin
            count_d = '0;
        end else if (advance) begin
            if (terminal) begin
                count_d        = '0;
                active_tempo_d = tempo;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            active_tempo_q <= '0;
        end else begin
            count_q        <= count_d;
            active_tempo_q <= active_tempo_d;
        end
    end

endmodule

// File: rtl/beat_clock.sv
// Run/stop beat clock: emits a pulse per beat and tracks the step within a bar.
module beat_clock #(
    parameter int TEMPO_W = beat_clock_pkg::TEMPO_W,
    parameter int STEPS   = beat_clock_pkg::STEPS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TEMPO_W-1:0]       tempo,
    input  logic                     run_toggle,
    input  logic                     clear,
    output logic                     beat_pulse,
    output logic                     bar_pulse,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     running
);
    import beat_clock_pkg::*;

    localparam int STEP_W = $clog2(STEPS);

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d, step_inc;
    logic               beat_q, beat_d;
    logic               bar_q, bar_d;
    logic               pc_restart, pc_zero, pc_advance, terminal;

    period_counter #(.TEMPO_W(TEMPO_W)) u_period (
        .clk      (clk),
        .rst      (rst),
        .restart  (pc_restart),
        .zero     (pc_zero),
        .advance  (pc_advance),
        .tempo    (tempo),
        .terminal (terminal)
    );

    assign step_inc = step_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        beat_d     = 1'b0;
        bar_d      = 1'b0;
        pc_restart = 1'b0;
        pc_zero    = 1'b0;
        pc_advance = 1'b0;
        case (state_q)
            STOP: begin
                if (run_toggle) begin
                    state_d    = RUN;
                    step_d     = '0;
                    beat_d     = 1'b1;
                    bar_d      = 1'b1;
                    pc_restart = 1'b1;
                end else if (clear) begin
                    step_d  = '0;
                    pc_zero = 1'b1;
                end
            end
            RUN: begin
                // run_toggle wins over clear; clear alone restarts on a downbeat
                if (run_toggle) begin
                    state_d = STOP;
                    if (clear) begin
                        step_d  = '0;
                        pc_zero = 1'b1;
                    end
                end else if (clear) begin
                    step_d     = '0;
                    beat_d     = 1'b1;
                    bar_d      = 1'b1;
                    pc_restart = 1'b1;
                end else begin
                    pc_advance = 1'b1;
                    if (terminal) begin
                        step_d = step_inc;
                        beat_d = 1'b1;
                        bar_d  = (step_inc == '0);
                    end
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STOP;
            step_q  <= '0;
            beat_q  <= 1'b0;
            bar_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            beat_q  <= beat_d;
            bar_q   <= bar_d;
        end
    end

    assign beat_pulse = beat_q;
    assign bar_pulse  = bar_q;
    assign step       = step_q;
    assign running    = (state_q == RUN);

endmodule

// File: tb/tb_beat_clock.sv
// Bench for beat_clock: timestamp-based beat model plus directed literal checks.
module tb_beat_clock;

    localparam int TW = 23;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [TW-1:0] tempo;
    logic          run_toggle, clear;
    logic          beat_pulse, bar_pulse, running;
    logic [2:0]    step;

    beat_clock dut (
        .clk        (clk),
        .rst        (rst),
        .tempo      (tempo),
        .run_toggle (run_toggle),
        .clear      (clear),
        .beat_pulse (beat_pulse),
        .bar_pulse  (bar_pulse),
        .step       (step),
        .running    (running)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: running flag, step, and the absolute cycle of the next due beat.
    bit     m_run, m_beat, m_bar;
    int     m_step;
    longint cyc, m_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_start(input int tp);
        m_run  = 1;
        m_step = 0;
        m_beat = 1;
        m_bar  = 1;
        m_next = cyc + tp + 1;
    endtask

    task automatic model_edge(input bit rt, input bit cl, input int tp);
        cyc++;
        if (!m_run) begin
            if (rt) model_start(tp);
            else begin
                m_beat = 0;
                m_bar  = 0;
                if (cl) m_step = 0;
            end
        end else if (rt) begin
            m_run  = 0;
            m_beat = 0;
            m_bar  = 0;
            if (cl) m_step = 0;
        end else if (cl) begin
            model_start(tp);
        end else if (cyc == m_next) begin
            m_step = (m_step + 1) % 8;
            m_beat = 1;
            m_bar  = (m_step == 0);
            m_next = cyc + tp + 1;
        end else begin
            m_beat = 0;
            m_bar  = 0;
        end
    endtask

    task automatic compare_model();
        chk("beat", beat_pulse, m_beat);
        chk("bar", bar_pulse, m_bar);
        chk("step", step, m_step);
        chk("running", running, m_run);
    endtask

    task automatic tick(input bit rt, input bit cl, input int tp);
        @(negedge clk);
        run_toggle = rt;
        clear      = cl;
        tempo      = tp[TW-1:0];
        @(posedge clk);
        model_edge(rt, cl, tp);
        #1;
        compare_model();
    endtask

    // Asserted 3 time units after an edge, i.e. asynchronously to clk.
    task automatic do_reset();
        #2;
        rst    = 1'b1;
        m_run  = 0;
        m_beat = 0;
        m_bar  = 0;
        m_step = 0;
        #1;
        chk("rst_beat", beat_pulse, 0);
        chk("rst_bar", bar_pulse, 0);
        chk("rst_step", step, 0);
        chk("rst_running", running, 0);
        @(posedge clk);
        @(negedge clk);
        run_toggle = 1'b0;
        clear      = 1'b0;
        rst        = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cur_tp;
        run_toggle = 1'b0;
        clear      = 1'b0;
        tempo      = '0;
        cyc        = 0;
        m_next     = 0;
        do_reset();

        // Start at tempo 3: beats on cycles 1,5,9,..., bars on 1 and 33
        tick(1, 0, 3);
        for (int k = 1; k <= 36; k++) begin
            chk("p29_beat", beat_pulse, ((k - 1) % 4) == 0);
            chk("p29_step", step, ((k - 1) / 4) % 8);
            chk("p29_bar", bar_pulse, ((k - 1) % 32) == 0);
            tick(0, 0, 3);
        end

        // At a beat now; tempo drops to 1 two cycles later
        tick(0, 0, 3);
        chk("p30_beat_r1", beat_pulse, 0);
        tick(0, 0, 1);
        chk("p30_beat_r2", beat_pulse, 0);
        for (int rel = 3; rel <= 10; rel++) begin
            tick(0, 0, 1);
            chk("p30_beat", beat_pulse, (rel % 2) == 0);
        end

        // Stop at step 5, then clear while stopped
        for (int i = 0; i < 100 && !(m_beat && m_step == 5); i++) tick(0, 0, 3);
        chk("p31_sync", (m_beat && m_step == 5), 1);
        tick(1, 0, 3);
        chk("p31_running", running, 0);
        chk("p31_step", step, 5);
        chk("p31_beat", beat_pulse, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 3);
            chk("p31_hold_step", step, 5);
            chk("p31_hold_beat", beat_pulse, 0);
        end
        tick(0, 1, 3);
        chk("p31_clr_step", step, 0);
        chk("p31_clr_beat", beat_pulse, 0);
        chk("p31_clr_running", running, 0);

        // Clear mid-beat at step 3 restarts on a downbeat
        tick(1, 0, 3);
        chk("p32_start_bar", bar_pulse, 1);
        for (int i = 0; i < 100 && !(m_beat && m_step == 3); i++) tick(0, 0, 3);
        chk("p32_sync", (m_beat && m_step == 3), 1);
        tick(0, 0, 3);
        tick(0, 0, 3);
        tick(0, 1, 3);
        chk("p32_beat", beat_pulse, 1);
        chk("p32_bar", bar_pulse, 1);
        chk("p32_step", step, 0);
        for (int rel = 1; rel <= 4; rel++) begin
            tick(0, 0, 3);
            chk("p32_after_beat", beat_pulse, rel == 4);
            chk("p32_after_step", step, (rel == 4) ? 1 : 0);
        end

        // Tempo 0: a beat every cycle
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("p33_start_bar", bar_pulse, 1);
        for (int k = 1; k <= 10; k++) begin
            tick(0, 0, 0);
            chk("p33_beat", beat_pulse, 1);
            chk("p33_step", step, k % 8);
            chk("p33_bar", bar_pulse, (k % 8) == 0);
        end

        // Async reset landing on a beat cycle
        tick(1, 0, 0);
        tick(1, 0, 3);
        for (int i = 0; i < 100 && !(m_beat && m_step == 2); i++) tick(0, 0, 3);
        chk("p34_sync", (m_beat && m_step == 2), 1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 3);
            chk("p34_idle_beat", beat_pulse, 0);
            chk("p34_idle_running", running, 0);
        end

        // Randomized run/clear/tempo traffic
        cur_tp = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) cur_tp = $urandom_range(0, 5);
                tick($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, cur_tp);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
